serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 115 +++++++++++
 tb/tb_serial_adder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a registered carry, LSB first,
// with valid/ready handshakes on the operand and result sides.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             busy_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              c_q, c_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic              bit_s;
  logic              bit_c;

  // The single full-adder cell shared by every bit position.
  assign bit_s = a_q[0] ^ b_q[0] ^ c_q;
  assign bit_c = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          a_d     = a_i;
          b_d     = b_i;
          c_d     = cin_i;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d            = sum_q >> 1;
        sum_d[WIDTH-1]   = bit_s;
        a_d              = a_q >> 1;
        b_d              = b_q >> 1;
        c_d              = bit_c;
        if (cnt_q == LastBit) begin
          // Counter is held on the last bit so it never wraps.
          cout_d  = bit_c;
          ovf_d   = c_q ^ bit_c;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign busy_o      = (state_q == StRun);
  assign sum_o       = sum_q;
  assign cout_o      = cout_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: expected results are queued at operand accept and
// compared when out_valid rises.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  res_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .cin_i       (cin),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .sum_o       (sum),
    .cout_o      (cout),
    .ovf_o       (ovf),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: wide unsigned sum for sum/cout, signed-range test for overflow.
  function automatic res_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    res_t        r;
    logic [W:0]  u;
    int          s;
    u      = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
    s      = int'($signed(av)) + int'($signed(bv)) + int'(cv);
    r.sum  = u[W-1:0];
    r.cout = u[W];
    r.ovf  = (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
    return r;
  endfunction

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                        input int stall);
    res_t exp;
    int   lat;
    lat = 0;
    while (!in_ready && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("in_ready_before_op", in_ready, 1);
    a        = av;
    b        = bv;
    cin      = cv;
    in_valid = 1'b1;
    sb_q.push_back(model(av, bv, cv));
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    cin      = 1'($urandom);
    check_eq("busy_in_run", busy, 1);
    check_eq("in_ready_in_run", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("latency", lat, W);
    if (sb_q.size() == 0) begin
      check_eq("scoreboard_empty", 1, 0);
      return;
    end
    exp = sb_q.pop_front();
    check_eq("sum", sum, exp.sum);
    check_eq("cout", cout, exp.cout);
    check_eq("ovf", ovf, exp.ovf);
    // Stall the result while waving garbage on the input side.
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom);
      a        = W'($urandom);
      b        = W'($urandom);
      cin      = 1'($urandom);
      @(posedge clk); #1;
      check_eq("stall_out_valid", out_valid, 1);
      check_eq("stall_in_ready", in_ready, 0);
      check_eq("stall_sum", sum, exp.sum);
      check_eq("stall_cout", cout, exp.cout);
      check_eq("stall_ovf", ovf, exp.ovf);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("out_valid_drop", out_valid, 0);
    check_eq("in_ready_back", in_ready, 1);
    check_eq("sum_retained", sum, exp.sum);
  endtask

  initial begin
    // Reset held while clock and inputs toggle.
    for (int i = 0; i < 4; i++) begin
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      a         = W'($urandom);
      b         = W'($urandom);
      cin       = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_sum", sum, 0);
    check_eq("rst_cout", cout, 0);
    check_eq("rst_ovf", ovf, 0);

    run_op(8'hFF, 8'h01, 1'b0, 0);
    run_op(8'h5A, 8'h3C, 1'b1, 0);
    run_op(8'h7F, 8'h01, 1'b0, 0);
    run_op(8'h80, 8'h80, 1'b0, 0);
    run_op(8'hC3, 8'h4E, 1'b1, 5);
    run_op(8'h21, 8'h9D, 1'b0, 0);

    // Abort an operation after three bit cycles.
    a        = 8'hAA;
    b        = 8'h55;
    cin      = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check_eq("pre_abort_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_in_ready", in_ready, 1);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_out_valid", out_valid, 0);
    check_eq("abort_sum", sum, 0);
    check_eq("abort_cout", cout, 0);
    check_eq("abort_ovf", ovf, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_no_result", out_valid, 0);
    run_op(8'h12, 8'h34, 1'b0, 0);

    for (int i = 0; i < 12; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end

    check_eq("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1, "timeout");
  end

endmodule
